ppu_seq_ctrl: RTL and testbench

//  Sequencer between the PPU and vga_driver. On each frame start it loads the PPU's NPARAM-byte

---
 rtl/ppu_seq_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_ppu_seq_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_seq_ctrl.sv
// ppu_seq_ctrl: loads the PPU parameter table at frame start, then runs the
// PPU and forwards its pixel bytes to vga_driver. The host may rewrite the
// table and the mode at any time; edits only reach the PPU at the next load.
//
// Handshakes (both sides): a transfer happens on any rising clk_pix edge
// where the producer's strobe and the consumer's ack are both high. The
// producer holds its data stable from the cycle the strobe rises until that
// edge. The ack may be high before the strobe rises.
module ppu_seq_ctrl #(
    parameter int         NPARAM   = 10,
    parameter int         TIMEOUT  = 255,
    parameter logic [2:0] MODE_RST = 3'd1
) (
    input  logic       clk_pix,
    input  logic       rst_pix,
    input  logic       enable,
    input  logic       frame_start,
    input  logic       cfg_we,
    input  logic [3:0] cfg_addr,
    input  logic [7:0] cfg_wdata,
    input  logic       mode_we,
    input  logic [2:0] mode_wdata,
    input  logic       err_clr,
    output logic       ppu_sync,
    output logic [2:0] ppu_mode,
    output logic [7:0] ppu_data,
    output logic       ppu_stb,
    input  logic       ppu_ack,
    input  logic [7:0] ppu_pix_data,
    input  logic       ppu_pix_stb,
    output logic       ppu_pix_ack,
    output logic [5:0] pix_rgb,
    output logic       busy,
    output logic       load_err,
    output logic [1:0] dbg_state
);

    localparam int         TW       = $clog2(TIMEOUT + 1);
    localparam logic [3:0] LAST_IDX = 4'(NPARAM - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      idx_q, idx_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [7:0]      tbl_q [NPARAM];
    logic [7:0]      tbl_d [NPARAM];
    logic [2:0]      shadow_q, shadow_d;
    logic            reload_q, reload_d;
    logic            sync_q, sync_d;
    logic [2:0]      mode_q, mode_d;
    logic [7:0]      data_q, data_d;
    logic            stb_q, stb_d;
    logic            pix_ack_q, pix_ack_d;
    logic [5:0]      rgb_q, rgb_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;
    logic            wr_tbl;
    logic            start_load;

    // The two low pixel bits carry no colour information.
    logic            pix_lo_unused;
    assign pix_lo_unused = ^ppu_pix_data[1:0];

    // Next-state logic: host writes first, then the sequencer; reads of the
    // table and shadow mode below always see the pre-write values.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        timer_d    = timer_q;
        tbl_d      = tbl_q;
        shadow_d   = shadow_q;
        reload_d   = reload_q;
        sync_d     = sync_q;
        mode_d     = mode_q;
        data_d     = data_q;
        stb_d      = stb_q;
        pix_ack_d  = pix_ack_q;
        rgb_d      = rgb_q;
        err_d      = err_q;
        start_load = 1'b0;

        wr_tbl = cfg_we && (int'(cfg_addr) < NPARAM);
        if (wr_tbl) begin
            tbl_d[cfg_addr] = cfg_wdata;
            reload_d        = 1'b1;
        end
        if (mode_we) begin
            shadow_d = mode_wdata;
            reload_d = 1'b1;
        end
        if (err_clr) begin
            err_d = 1'b0;
        end

        if (!enable) begin
            // Abandon whatever is in flight; the next frame must reload.
            state_d   = ST_IDLE;
            idx_d     = '0;
            timer_d   = '0;
            stb_d     = 1'b0;
            sync_d    = 1'b0;
            pix_ack_d = 1'b0;
            rgb_d     = '0;
            reload_d  = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    start_load = frame_start;
                end
                ST_LOAD: begin
                    if (stb_q && ppu_ack) begin
                        if (idx_q == LAST_IDX) begin
                            state_d   = ST_RUN;
                            stb_d     = 1'b0;
                            sync_d    = 1'b0;
                            idx_d     = '0;
                            pix_ack_d = 1'b1;
                        end else begin
                            idx_d   = idx_q + 4'd1;
                            timer_d = '0;
                            data_d  = tbl_q[idx_q + 4'd1];
                        end
                    end else if (timer_q == TW'(TIMEOUT - 1)) begin
                        // This cycle's count reaches TIMEOUT: give up the load.
                        state_d  = ST_IDLE;
                        stb_d    = 1'b0;
                        sync_d   = 1'b0;
                        timer_d  = '0;
                        reload_d = 1'b1;
                        err_d    = 1'b1;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                ST_RUN: begin
                    if (ppu_pix_stb) begin
                        rgb_d = ppu_pix_data[7:2];
                    end
                    start_load = frame_start && reload_q;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (start_load) begin
            state_d   = ST_LOAD;
            idx_d     = '0;
            timer_d   = '0;
            stb_d     = 1'b1;
            sync_d    = 1'b1;
            pix_ack_d = 1'b0;
            data_d    = tbl_q[0];
            mode_d    = shadow_q;
            // A write landing on the entry cycle still needs a later load.
            reload_d  = wr_tbl || mode_we;
        end

        busy_d = (state_d == ST_LOAD);
    end

    // State, table and every output register.
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            timer_q   <= '0;
            for (int i = 0; i < NPARAM; i++) begin
                tbl_q[i] <= '0;
            end
            shadow_q  <= MODE_RST;
            reload_q  <= 1'b1;
            sync_q    <= 1'b0;
            mode_q    <= MODE_RST;
            data_q    <= '0;
            stb_q     <= 1'b0;
            pix_ack_q <= 1'b0;
            rgb_q     <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            timer_q   <= timer_d;
            tbl_q     <= tbl_d;
            shadow_q  <= shadow_d;
            reload_q  <= reload_d;
            sync_q    <= sync_d;
            mode_q    <= mode_d;
            data_q    <= data_d;
            stb_q     <= stb_d;
            pix_ack_q <= pix_ack_d;
            rgb_q     <= rgb_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    assign ppu_sync    = sync_q;
    assign ppu_mode    = mode_q;
    assign ppu_data    = data_q;
    assign ppu_stb     = stb_q;
    assign ppu_pix_ack = pix_ack_q;
    assign pix_rgb     = rgb_q;
    assign busy        = busy_q;
    assign load_err    = err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_ppu_seq_ctrl.sv
// tb_ppu_seq_ctrl: directed scenarios plus a random soak, checked every cycle
// against a behavioural model of the sequencer and a PPU-side byte scoreboard.
module tb_ppu_seq_ctrl;

    localparam int NPARAM  = 10;
    localparam int TIMEOUT = 255;
    localparam int P_IDLE  = 0;
    localparam int P_LOAD  = 1;
    localparam int P_RUN   = 2;

    // ---------------- clock / reset ----------------
    logic       clk_pix = 1'b0;
    logic       rst_pix = 1'b1;
    logic       enable = 1'b0, frame_start = 1'b0;
    logic       cfg_we = 1'b0, mode_we = 1'b0, err_clr = 1'b0;
    logic [3:0] cfg_addr = '0;
    logic [7:0] cfg_wdata = '0;
    logic [2:0] mode_wdata = '0;
    logic       ppu_ack = 1'b0, ppu_pix_stb = 1'b0;
    logic [7:0] ppu_pix_data = '0;
    logic       ppu_sync, ppu_stb, ppu_pix_ack, busy, load_err;
    logic [2:0] ppu_mode;
    logic [7:0] ppu_data;
    logic [5:0] pix_rgb;
    logic [1:0] dbg_state;

    always #5 clk_pix = ~clk_pix;

    ppu_seq_ctrl #(.NPARAM(NPARAM), .TIMEOUT(TIMEOUT), .MODE_RST(3'd1)) dut (
        .clk_pix(clk_pix), .rst_pix(rst_pix), .enable(enable), .frame_start(frame_start),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .mode_we(mode_we), .mode_wdata(mode_wdata), .err_clr(err_clr),
        .ppu_sync(ppu_sync), .ppu_mode(ppu_mode), .ppu_data(ppu_data), .ppu_stb(ppu_stb),
        .ppu_ack(ppu_ack), .ppu_pix_data(ppu_pix_data), .ppu_pix_stb(ppu_pix_stb),
        .ppu_pix_ack(ppu_pix_ack), .pix_rgb(pix_rgb), .busy(busy), .load_err(load_err),
        .dbg_state(dbg_state)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phase decides the handshake outputs: loading drives sync/stb/busy,
    // running drives pix_ack. Counters follow the documented rules directly.
    logic [7:0] m_tbl [16];
    int         m_phase, m_idx, m_wait;
    logic [2:0] m_shadow, m_mode;
    logic       m_reload, m_err;
    logic [5:0] m_rgb;
    logic [7:0] m_data;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_tbl[i] = '0;
        m_phase = P_IDLE; m_idx = 0; m_wait = 0;
        m_shadow = 3'd1; m_mode = 3'd1;
        m_reload = 1'b1; m_err = 1'b0; m_rgb = '0; m_data = '0;
    endfunction

    function automatic void model_edge();
        int  ph = m_phase;
        bit  start = 0;
        bit  tmo = 0;
        bit  wr = cfg_we && (int'(cfg_addr) < NPARAM);
        if (!enable) begin
            ph = P_IDLE; m_rgb = '0; m_reload = 1'b1;
        end else if (m_phase == P_IDLE) begin
            start = frame_start;
        end else if (m_phase == P_LOAD) begin
            if (ppu_ack) begin
                if (m_idx == NPARAM - 1) ph = P_RUN;
                else begin m_idx++; m_wait = 0; m_data = m_tbl[m_idx]; end
            end else begin
                m_wait++;
                if (m_wait == TIMEOUT) begin ph = P_IDLE; tmo = 1; m_reload = 1'b1; end
            end
        end else begin
            if (ppu_pix_stb) m_rgb = ppu_pix_data[7:2];
            start = frame_start && m_reload;
        end
        if (start) begin
            ph = P_LOAD; m_idx = 0; m_wait = 0;
            m_data = m_tbl[0]; m_mode = m_shadow; m_reload = 1'b0;
        end
        // Host edits land after the load logic has read the old values.
        if (wr) begin m_tbl[cfg_addr] = cfg_wdata; m_reload = 1'b1; end
        if (mode_we) begin m_shadow = mode_wdata; m_reload = 1'b1; end
        if (tmo) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
        m_phase = ph;
    endfunction

    function automatic logic [13:0] exp_vec();
        return {m_phase == P_LOAD, m_mode, m_phase == P_LOAD, m_phase == P_RUN,
                m_rgb, m_phase == P_LOAD, m_err};
    endfunction

    function automatic logic [13:0] obs_vec();
        return {ppu_sync, ppu_mode, ppu_stb, ppu_pix_ack, pix_rgb, busy, load_err};
    endfunction

    // ---------------- driver tasks / scoreboard ----------------
    logic [7:0] exp_q[$];
    bit         sb_on = 0;
    int         ack_mode = 0;   // -1 never, 0..N ack after N presented cycles, 99 random
    int         stb_age = 0;

    task automatic tick();
        @(posedge clk_pix);
        if (rst_pix) model_reset();
        else model_edge();
        #1;
        check("outs", 32'(obs_vec()), 32'(exp_vec()));
        if (m_phase == P_LOAD) check("ppu_data", 32'(ppu_data), 32'(m_data));
    endtask

    task automatic run_cycle();
        bit         acc;
        bit         stb_was;
        logic [7:0] b;
        if (ack_mode == 99) ppu_ack = ($urandom_range(0, 9) < 6);
        else if (ack_mode < 0) ppu_ack = 1'b0;
        else ppu_ack = ppu_stb && (stb_age >= ack_mode);
        stb_was = ppu_stb;
        acc = ppu_stb && ppu_ack;
        b = ppu_data;
        tick();
        if (acc) begin
            stb_age = 0;
            if (sb_on) begin
                if (exp_q.size() == 0) check("sb_extra_byte", 32'(b), 32'h100);
                else check("sb_byte", 32'(b), 32'(exp_q.pop_front()));
            end
        end else if (stb_was) stb_age++;
        else stb_age = 0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        run_cycle();
        frame_start = 1'b0;
    endtask

    task automatic write_cfg(input logic [3:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        run_cycle();
        cfg_we = 1'b0;
    endtask

    task automatic sb_expect_table();
        exp_q.delete();
        for (int i = 0; i < NPARAM; i++) exp_q.push_back(m_tbl[i]);
    endtask

    // Runs until the PPU pixel side opens; returns cycles with ppu_sync high.
    task automatic wait_run(input int budget, output int sync_cnt);
        int k;
        sync_cnt = ppu_sync ? 1 : 0;
        for (k = 0; k < budget && !ppu_pix_ack; k++) begin
            run_cycle();
            if (ppu_sync) sync_cnt++;
        end
        if (!ppu_pix_ack) check("wait_run_budget", 32'(k), 32'(budget + 1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] vals [NPARAM];
        int cnt;
        vals = '{8'd42, 8'd123, 8'd87, 8'd255, 8'd0, 8'd198, 8'd76, 8'd34, 8'd210, 8'd99};
        model_reset();

        // Reset
        tick();
        tick();
        check("rst_mode", 32'(ppu_mode), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_stb", 32'(ppu_stb), 32'd0);
        @(negedge clk_pix);
        rst_pix = 1'b0;
        enable = 1'b1;

        // T1: table load, PPU acks every cycle
        for (int i = 0; i < NPARAM; i++) write_cfg(4'(i), vals[i]);
        ack_mode = 0;
        sb_expect_table();
        sb_on = 1;
        pulse_frame();
        check("t1_first_byte", 32'(ppu_data), 32'd42);
        wait_run(40, cnt);
        check("t1_sync_cycles", 32'(cnt), 32'd10);
        check("t1_run", 32'(ppu_pix_ack), 32'd1);
        check("t1_sb_empty", 32'(exp_q.size()), 32'd0);

        // T2: ack delayed 3 cycles per byte
        write_cfg(4'd3, 8'h5A);
        ack_mode = 3;
        sb_expect_table();
        pulse_frame();
        wait_run(100, cnt);
        check("t2_sync_cycles", 32'(cnt), 32'd40);
        check("t2_sb_empty", 32'(exp_q.size()), 32'd0);

        // T4: pixel path, no-reload frame, mode change at LOAD entry
        ack_mode = 0;
        ppu_pix_stb = 1'b1; ppu_pix_data = 8'hB4;
        run_cycle();
        ppu_pix_stb = 1'b0; ppu_pix_data = 8'h00;
        check("t4_rgb", 32'(pix_rgb), 32'h2D);
        run_cycle();
        check("t4_rgb_hold", 32'(pix_rgb), 32'h2D);
        pulse_frame();
        check("t4_no_reload", 32'(busy), 32'd0);
        mode_we = 1'b1; mode_wdata = 3'd4;
        run_cycle();
        mode_we = 1'b0;
        check("t4_mode_not_yet", 32'(ppu_mode), 32'd1);
        pulse_frame();
        check("t4_mode_at_load", 32'(ppu_mode), 32'd4);
        check("t4_reload_busy", 32'(busy), 32'd1);
        sb_expect_table();
        wait_run(40, cnt);
        check("t4_sb_empty", 32'(exp_q.size()), 32'd0);

        // T3: PPU never acks -> timeout
        write_cfg(4'd9, 8'h11);
        ack_mode = -1;
        sb_on = 0;
        pulse_frame();
        cnt = 0;
        for (int k = 0; k < 400 && busy; k++) begin
            run_cycle();
            cnt++;
        end
        check("t3_timeout_cycles", 32'(cnt), 32'd255);
        check("t3_load_err", 32'(load_err), 32'd1);
        check("t3_stb_low", 32'(ppu_stb), 32'd0);
        err_clr = 1'b1;
        run_cycle();
        err_clr = 1'b0;
        check("t3_err_clr", 32'(load_err), 32'd0);

        // T5: enable drops mid-load at idx 5
        ack_mode = 0;
        pulse_frame();
        for (int k = 0; k < 20 && m_idx != 5; k++) run_cycle();
        check("t5_reach_idx5", 32'(m_idx), 32'd5);
        enable = 1'b0;
        run_cycle();
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_stb", 32'(ppu_stb), 32'd0);
        check("t5_no_err", 32'(load_err), 32'd0);
        enable = 1'b1;
        sb_expect_table();
        sb_on = 1;
        pulse_frame();
        wait_run(40, cnt);
        check("t5_sb_empty", 32'(exp_q.size()), 32'd0);
        sb_on = 0;

        // Random soak
        ack_mode = 99;
        for (int k = 0; k < 2000; k++) begin
            enable       = ($urandom_range(0, 59) != 0);
            frame_start  = ($urandom_range(0, 24) == 0);
            cfg_we       = ($urandom_range(0, 7) == 0);
            cfg_addr     = 4'($urandom_range(0, 15));
            cfg_wdata    = 8'($urandom);
            mode_we      = ($urandom_range(0, 29) == 0);
            mode_wdata   = 3'($urandom);
            err_clr      = ($urandom_range(0, 19) == 0);
            ppu_pix_stb  = ($urandom_range(0, 1) == 1);
            ppu_pix_data = 8'($urandom);
            run_cycle();
        end
        enable = 1'b1; frame_start = 1'b0; cfg_we = 1'b0; mode_we = 1'b0;
        err_clr = 1'b0; ppu_pix_stb = 1'b0;

        // T6: asynchronous reset mid-RUN
        ack_mode = 0;
        write_cfg(4'd0, 8'h77);
        for (int k = 0; k < 30 && !ppu_pix_ack; k++) pulse_frame();
        check("t6_in_run", 32'(ppu_pix_ack), 32'd1);
        ppu_pix_stb = 1'b1; ppu_pix_data = 8'hFC;
        run_cycle();
        ppu_pix_stb = 1'b0;
        check("t6_rgb_before", 32'(pix_rgb), 32'h3F);
        @(posedge clk_pix);
        model_edge();
        #3;
        rst_pix = 1'b1;
        #1;
        check("t6_rgb", 32'(pix_rgb), 32'd0);
        check("t6_pix_ack", 32'(ppu_pix_ack), 32'd0);
        check("t6_sync_stb", 32'({ppu_sync, ppu_stb, busy, load_err}), 32'd0);
        check("t6_mode", 32'(ppu_mode), 32'd1);
        model_reset();
        tick();
        @(negedge clk_pix);
        rst_pix = 1'b0;
        pulse_frame();
        check("t6_reload_after_rst", 32'(ppu_data), 32'd0);
        wait_run(40, cnt);
        check("t6_sync_cycles", 32'(cnt), 32'd10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
